fifo_sram_v4: RTL and testbench



---
 rtl/fifo_sram_v4.sv | 177 +++++++++++++++++
 tb/tb_fifo_sram_v4.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sram_v4.sv
// rtl/fifo_sram_v4.sv - parametrised FWFT FIFO on an inferred 1R1W SRAM plus output register
// Optional feature macro: FIFO_SRAM_FALL_THROUGH_EN (combinational push-to-data_o path while empty).
module fifo_sram_v4 #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 512,
    parameter int ALMOST_FULL_TH  = 384,
    parameter int ALMOST_EMPTY_TH = 128,
    parameter int ADDR_DEPTH      = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_DEPTH:0]   usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int RAM_DEPTH = DEPTH - 1;
    localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int CW        = ADDR_DEPTH + 1;

    localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]     AF_TH_C  = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0]     AE_TH_C  = CW'(ALMOST_EMPTY_TH);
    localparam logic [RAM_AW-1:0] PTR_LAST = RAM_AW'(RAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] ram_rdata_q;

    logic [RAM_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [RAM_AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
    logic [CW-1:0]         usage_q, usage_d;
    logic                  oreg_valid_q, oreg_valid_d;
    logic                  src_ram_q, src_ram_d;
    logic [DATA_WIDTH-1:0] oreg_q, oreg_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  push_acc, pop_acc, oreg_free;
    logic                  rd_en, wr_en, byp_en, ft_consume;
    logic                  mem_we, mem_re;
    logic [DATA_WIDTH-1:0] oreg_data;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    // OREG is either the bypass register or the RAM read register, chosen by src_ram_q.
    assign oreg_data = src_ram_q ? ram_rdata_q : oreg_q;

`ifdef FIFO_SRAM_FALL_THROUGH_EN
    assign empty_o = !oreg_valid_q && !push_i;
    assign data_o  = (!oreg_valid_q && push_i) ? data_i : oreg_data;
`else
    assign empty_o = !oreg_valid_q;
    assign data_o  = oreg_data;
`endif

    assign full_o         = (usage_q == DEPTH_C);
    assign almost_full_o  = (usage_q >= AF_TH_C);
    assign almost_empty_o = (usage_q <= AE_TH_C);
    assign usage_o        = usage_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    always_comb begin
        push_acc  = push_i && !full_o;
        pop_acc   = pop_i && !empty_o;
        oreg_free = !oreg_valid_q || pop_acc;
`ifdef FIFO_SRAM_FALL_THROUGH_EN
        ft_consume = !oreg_valid_q && push_acc && pop_acc;
`else
        ft_consume = 1'b0;
`endif
        // OREG only empties when the RAM is empty, so a read always targets a free OREG.
        rd_en  = oreg_free && (ram_cnt_q != '0);
        byp_en = push_acc && oreg_free && (ram_cnt_q == '0) && !ft_consume;
        wr_en  = push_acc && !byp_en && !ft_consume;
        mem_we = wr_en && !flush_i;
        mem_re = rd_en && !flush_i;

        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + RAM_AW'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + RAM_AW'(1);
        end

        ram_cnt_d = ram_cnt_q;
        if (wr_en && !rd_en) begin
            ram_cnt_d = ram_cnt_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            ram_cnt_d = ram_cnt_q - CW'(1);
        end

        usage_d = usage_q;
        if (push_acc && !pop_acc) begin
            usage_d = usage_q + CW'(1);
        end else if (pop_acc && !push_acc) begin
            usage_d = usage_q - CW'(1);
        end

        oreg_valid_d = oreg_valid_q;
        src_ram_d    = src_ram_q;
        oreg_d       = oreg_q;
        if (rd_en) begin
            oreg_valid_d = 1'b1;
            src_ram_d    = 1'b1;
        end else if (byp_en) begin
            oreg_valid_d = 1'b1;
            src_ram_d    = 1'b0;
            oreg_d       = data_i;
        end else if (pop_acc) begin
            oreg_valid_d = 1'b0;
        end

        overflow_d  = push_i && full_o;
        underflow_d = pop_i && empty_o;

        if (flush_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            ram_cnt_d    = '0;
            usage_d      = '0;
            oreg_valid_d = 1'b0;
            src_ram_d    = 1'b0;
            oreg_d       = '0;
            overflow_d   = 1'b0;
            underflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            usage_q      <= '0;
            oreg_valid_q <= 1'b0;
            src_ram_q    <= 1'b0;
            oreg_q       <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_cnt_q    <= ram_cnt_d;
            usage_q      <= usage_d;
            oreg_valid_q <= oreg_valid_d;
            src_ram_q    <= src_ram_d;
            oreg_q       <= oreg_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage array and its read register carry no reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= data_i;
        end
        if (mem_re) begin
            ram_rdata_q <= mem_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_fifo_sram_v4.sv
// tb/tb_fifo_sram_v4.sv - scoreboard bench for fifo_sram_v4 (DEPTH=512 and DEPTH=5 instances)
module tb_fifo_sram_v4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        d_flush = 0, d_push = 0, d_pop = 0;
    logic [31:0] d_data = 0, d_dout;
    logic        d_full, d_empty, d_af, d_ae, d_ovf, d_udf;
    logic [9:0]  d_usage;

    logic        s_flush = 0, s_push = 0, s_pop = 0;
    logic [7:0]  s_data = 0, s_dout;
    logic        s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [3:0]  s_usage;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] q[$];
    logic [7:0]  qs[$];

    fifo_sram_v4 #(.DATA_WIDTH(32), .DEPTH(512), .ALMOST_FULL_TH(384), .ALMOST_EMPTY_TH(128)) u_big (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(d_flush), .testmode_i(1'b0),
        .full_o(d_full), .empty_o(d_empty), .almost_full_o(d_af), .almost_empty_o(d_ae),
        .usage_o(d_usage), .data_i(d_data), .push_i(d_push), .data_o(d_dout), .pop_i(d_pop),
        .overflow_o(d_ovf), .underflow_o(d_udf)
    );

    fifo_sram_v4 #(.DATA_WIDTH(8), .DEPTH(5), .ALMOST_FULL_TH(4), .ALMOST_EMPTY_TH(1)) u_small (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(s_flush), .testmode_i(1'b0),
        .full_o(s_full), .empty_o(s_empty), .almost_full_o(s_af), .almost_empty_o(s_ae),
        .usage_o(s_usage), .data_i(s_data), .push_i(s_push), .data_o(s_dout), .pop_i(s_pop),
        .overflow_o(s_ovf), .underflow_o(s_udf)
    );

    task automatic drive_big(input logic push, input logic [31:0] din, input logic pop);
        bit acc_push, acc_pop;
        d_push = push; d_data = din; d_pop = pop;
        #1;
        acc_push = push && (q.size() < 512);
        acc_pop  = pop && (q.size() > 0);
        if (acc_pop) begin
            vectors++;
            if (d_dout !== q[0]) begin
                miscompares++;
                $display("FAIL big_pop_data actual=%h required=%h", d_dout, q[0]);
            end
            void'(q.pop_front());
        end
        if (acc_push) q.push_back(din);
        @(posedge clk); #1;
        d_push = 0; d_pop = 0;
        vectors += 3;
        if (d_usage !== 10'(q.size())) begin
            miscompares++;
            $display("FAIL big_usage actual=%0d required=%0d", d_usage, q.size());
        end
        if (d_ovf !== (push && !acc_push)) begin
            miscompares++;
            $display("FAIL big_overflow actual=%b required=%b", d_ovf, push && !acc_push);
        end
        if (d_udf !== (pop && !acc_pop)) begin
            miscompares++;
            $display("FAIL big_underflow actual=%b required=%b", d_udf, pop && !acc_pop);
        end
    endtask

    task automatic drive_small(input logic push, input logic [7:0] din, input logic pop);
        bit acc_push, acc_pop;
        s_push = push; s_data = din; s_pop = pop;
        #1;
        acc_push = push && (qs.size() < 5);
        acc_pop  = pop && (qs.size() > 0);
        if (acc_pop) begin
            vectors++;
            if (s_dout !== qs[0]) begin
                miscompares++;
                $display("FAIL small_pop_data actual=%h required=%h", s_dout, qs[0]);
            end
            void'(qs.pop_front());
        end
        if (acc_push) qs.push_back(din);
        @(posedge clk); #1;
        s_push = 0; s_pop = 0;
        vectors += 2;
        if (s_usage !== 4'(qs.size())) begin
            miscompares++;
            $display("FAIL small_usage actual=%0d required=%0d", s_usage, qs.size());
        end
        if (s_ovf !== (push && !acc_push)) begin
            miscompares++;
            $display("FAIL small_overflow actual=%b required=%b", s_ovf, push && !acc_push);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({d_empty, d_full, d_ae, d_af, d_ovf, d_udf} !== 6'b101000) begin
            miscompares++;
            $display("FAIL reset_flags actual=%b required=101000", {d_empty, d_full, d_ae, d_af, d_ovf, d_udf});
        end
        vectors++;
        if (d_usage !== 10'd0 || d_dout !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_usage_data actual=%0d/%h required=0/0", d_usage, d_dout);
        end
        vectors++;
        if (s_empty !== 1'b1 || s_usage !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_small actual=%b/%0d required=1/0", s_empty, s_usage);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive_big(1, 32'hA5, 0);
        vectors++;
        if (d_empty !== 1'b0 || d_dout !== 32'hA5) begin
            miscompares++;
            $display("FAIL single_push actual=%b/%h required=0/a5", d_empty, d_dout);
        end
        drive_big(0, 0, 1);
        vectors++;
        if (d_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL single_pop_empty actual=%b required=1", d_empty);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 512; i++) begin
            drive_big(1, 32'(i), 0);
            vectors++;
            if (d_af !== (i + 1 >= 384) || d_ae !== (i + 1 <= 128)) begin
                miscompares++;
                $display("FAIL fill_almost at usage %0d actual=%b%b required=%b%b",
                         i + 1, d_af, d_ae, i + 1 >= 384, i + 1 <= 128);
            end
        end
        vectors++;
        if (d_full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_flag actual=%b required=1", d_full);
        end
        drive_big(1, 32'h999, 0);
        drive_big(0, 0, 0);
        for (int i = 0; i < 512; i++) drive_big(0, 0, 1);
        vectors++;
        if (d_empty !== 1'b1 || d_full !== 1'b0) begin
            miscompares++;
            $display("FAIL drained_flags actual=%b%b required=10", d_empty, d_full);
        end
        drive_big(0, 0, 1);
        drive_big(0, 0, 0);
    endtask

    task automatic test_back_to_back();
        drive_small(1, 8'h00, 0);
        for (int i = 1; i <= 40; i++) drive_small(1, 8'(i), 1);
        for (int i = 41; i < 45; i++) drive_small(1, 8'(i), 0);
        vectors++;
        if (s_full !== 1'b1 || s_af !== 1'b1) begin
            miscompares++;
            $display("FAIL small_full actual=%b%b required=11", s_full, s_af);
        end
        for (int i = 45; i < 85; i++) drive_small(1, 8'(i), 1);
        while (qs.size() > 0) drive_small(0, 0, 1);
        vectors++;
        if (s_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL small_drain_empty actual=%b required=1", s_empty);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 200; i++) drive_big(1, 32'(i + 1000), 0);
        d_flush = 1; d_push = 1; d_pop = 1; d_data = 32'hDEAD;
        @(posedge clk); #1;
        d_flush = 0; d_push = 0; d_pop = 0;
        q.delete();
        vectors++;
        if (d_usage !== 10'd0 || d_empty !== 1'b1 || d_ovf !== 1'b0 || d_udf !== 1'b0) begin
            miscompares++;
            $display("FAIL flush actual=%0d/%b/%b/%b required=0/1/0/0", d_usage, d_empty, d_ovf, d_udf);
        end
        drive_big(1, 32'h3C, 0);
        drive_big(0, 0, 1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) drive_big(1, 32'(i + 50), 0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        vectors++;
        if (d_usage !== 10'd0 || d_empty !== 1'b1 || d_dout !== 32'd0 || d_ae !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset actual=%0d/%b/%h/%b required=0/1/0/1", d_usage, d_empty, d_dout, d_ae);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        d_push = 1; d_data = 32'h5A;
        @(posedge clk); #1;
        d_push = 0;
        vectors++;
        if (d_usage !== 10'd1 || d_empty !== 1'b0 || d_dout !== 32'h5A) begin
            miscompares++;
            $display("FAIL first_push_after_reset actual=%0d/%b/%h required=1/0/5a", d_usage, d_empty, d_dout);
        end
        q.push_back(32'h5A);
        drive_big(0, 0, 1);
    endtask

    task automatic test_fall_through();
        d_push = 1; d_pop = 1; d_data = 32'h77;
        #1;
`ifdef FIFO_SRAM_FALL_THROUGH_EN
        vectors++;
        if (d_dout !== 32'h77 || d_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL ft_same_cycle actual=%h/%b required=77/0", d_dout, d_empty);
        end
        @(posedge clk); #1;
        d_push = 0; d_pop = 0;
        vectors++;
        if (d_usage !== 10'd0 || d_udf !== 1'b0 || d_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL ft_consumed actual=%0d/%b/%b required=0/0/1", d_usage, d_udf, d_empty);
        end
`else
        vectors++;
        if (d_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL noft_empty actual=%b required=1", d_empty);
        end
        @(posedge clk); #1;
        d_push = 0; d_pop = 0;
        vectors++;
        if (d_usage !== 10'd1 || d_udf !== 1'b1 || d_dout !== 32'h77) begin
            miscompares++;
            $display("FAIL noft_after actual=%0d/%b/%h required=1/1/77", d_usage, d_udf, d_dout);
        end
        q.push_back(32'h77);
        drive_big(0, 0, 1);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_fall_through();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
